ltp_frame_tx: RTL and testbench

- Transmit-side counterpart of the team's LTP lamp decoder.
- Accepts 3-bit {L,T,P} control codes over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each code onto a single line, TXD, as a framed word. The remote receiver reconstructs L/T/P from the frame and feeds the decoder.
- Sits between the controller logic and the inter-board control line.

---
 rtl/ltp_frame_tx.sv | 181 ++++++++++++++++++
 tb/tb_ltp_frame_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ltp_frame_tx.sv
// Serial transmitter for LTP lamp codes: queues {L,T,P} words in a small FIFO and
// sends each one on TXD as start, L, T, P, odd parity, stop.
module ltp_frame_tx #(
  parameter int BIT_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        L,
  input  logic                        T,
  input  logic                        P,
  input  logic                        VALID,
  output logic                        READY,
  output logic                        TXD,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    CNT_MAX    = 8'(BIT_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic          ready_q;

  state_t        state;
  logic [7:0]    cnt;
  logic [1:0]    bitidx;
  logic [3:0]    shreg;

  logic          push;
  logic          pop;
  logic          nonempty;
  logic          bit_done;
  logic [2:0]    head;

  assign nonempty = (level != '0);
  assign bit_done = (cnt == CNT_MAX);
  assign head     = mem[rptr];
  assign push     = VALID && ready_q;
  // A new word is taken either from idle or at the very end of a stop bit,
  // which is what makes consecutive frames run back-to-back.
  assign pop      = nonempty && ((state == IDLE) || ((state == STOP) && bit_done));

  assign READY = ready_q;
  assign LEVEL = level;

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr] <= {L, T, P};
    end
  end

  // READY is computed from the next occupancy so it is a plain register output.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      level   <= level_next;
      ready_q <= (level_next != FULL_LEVEL);
    end
  end

  // The shift register holds {L,T,P,parity}; its MSB is the next bit to drive.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      TXD    <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            state  <= START;
            shreg  <= {head, ~^head};
            TXD    <= 1'b0;
            BUSY   <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            cnt    <= '0;
            bitidx <= '0;
            state  <= DATA;
            TXD    <= shreg[3];
            shreg  <= {shreg[2:0], 1'b0};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt   <= '0;
            TXD   <= shreg[3];
            shreg <= {shreg[2:0], 1'b0};
            if (bitidx == 2'd2) begin
              state <= PARITY;
            end else begin
              bitidx <= bitidx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= STOP;
            TXD   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (pop) begin
              state <= START;
              shreg <= {head, ~^head};
              TXD   <= 1'b0;
              BUSY  <= 1'b1;
            end else begin
              state <= IDLE;
              TXD   <= 1'b1;
              BUSY  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          TXD   <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ltp_frame_tx.sv
// Directed bench for ltp_frame_tx: one instance with 4-cycle bits, one with 1-cycle bits.
module tb_ltp_frame_tx;

  logic       clock = 1'b0;
  logic       rstN;
  logic       l, t, p, valid;
  logic       ready, txd, busy;
  logic [2:0] level;

  logic       rst1N;
  logic       l1, t1, p1, valid1;
  logic       ready1, txd1, busy1;
  logic [2:0] level1;

  int checks = 0;
  int errors = 0;

  ltp_frame_tx #(.BIT_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .CLK(clock), .RST_N(rstN), .L(l), .T(t), .P(p), .VALID(valid),
    .READY(ready), .TXD(txd), .BUSY(busy), .LEVEL(level)
  );

  ltp_frame_tx #(.BIT_CYCLES(1), .FIFO_DEPTH(4)) dut1 (
    .CLK(clock), .RST_N(rst1N), .L(l1), .T(t1), .P(p1), .VALID(valid1),
    .READY(ready1), .TXD(txd1), .BUSY(busy1), .LEVEL(level1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Time order of a frame, bit 0 first: start, L, T, P, odd parity, stop.
  function automatic logic [5:0] frameBits(input logic [2:0] code);
    return {1'b1, ~(code[2] ^ code[1] ^ code[0]), code[0], code[1], code[2], 1'b0};
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] code, input logic [5:0] expBits);
    valid = 1'b1;
    {l, t, p} = code;
    tick();
    valid = 1'b0;
    {l, t, p} = ~code;
    checkOutput({tag, "_level_after_push"}, 8'(level), 8'd1);
    checkOutput({tag, "_idle_before_pop"}, 8'(txd), 8'd1);
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        checkOutput($sformatf("%s_txd_bit%0d", tag, b), 8'(txd), 8'(expBits[b]));
        checkOutput($sformatf("%s_busy_bit%0d", tag, b), 8'(busy), 8'd1);
      end
    end
    tick();
    checkOutput({tag, "_busy_end"}, 8'(busy), 8'd0);
    checkOutput({tag, "_txd_end"}, 8'(txd), 8'd1);
  endtask

  logic [2:0] codes [6];
  logic       stream [120];
  logic [5:0] fb;
  logic [2:0] levelExp [6];
  logic       readyExp [6];
  int idx;

  initial begin
    rstN = 1'b0; valid = 1'b1; {l, t, p} = 3'b101;
    rst1N = 1'b0; valid1 = 1'b0; {l1, t1, p1} = 3'b000;

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_txd", 8'(txd), 8'd1);
      checkOutput("rst_ready", 8'(ready), 8'd0);
      checkOutput("rst_level", 8'(level), 8'd0);
      checkOutput("rst_busy", 8'(busy), 8'd0);
    end
    rstN = 1'b1; rst1N = 1'b1; valid = 1'b0;
    tick();
    checkOutput("rel_ready", 8'(ready), 8'd1);
    checkOutput("rel_level", 8'(level), 8'd0);
    checkOutput("rel_txd", 8'(txd), 8'd1);
    checkOutput("rel_busy", 8'(busy), 8'd0);

    applyStimulus("f101", 3'b101, 6'b111010);
    applyStimulus("f000", 3'b000, 6'b110000);
    applyStimulus("f111", 3'b111, 6'b101110);

    // Six back-to-back offers from idle; only five fit.
    codes = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    levelExp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    readyExp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int f = 0; f < 5; f++) begin
      fb = frameBits(codes[f]);
      for (int b = 0; b < 6; b++)
        for (int c = 0; c < 4; c++)
          stream[f*24 + b*4 + c] = fb[b];
    end
    idx = 0;
    valid = 1'b1;
    {l, t, p} = codes[0];
    tick();
    checkOutput("bp_level0", 8'(level), 8'(levelExp[0]));
    checkOutput("bp_ready0", 8'(ready), 8'(readyExp[0]));
    for (int k = 1; k < 6; k++) begin
      {l, t, p} = codes[k];
      tick();
      checkOutput($sformatf("bp_level%0d", k), 8'(level), 8'(levelExp[k]));
      checkOutput($sformatf("bp_ready%0d", k), 8'(ready), 8'(readyExp[k]));
      checkOutput($sformatf("bp_txd%0d", idx), 8'(txd), 8'(stream[idx]));
      checkOutput($sformatf("bp_busy%0d", idx), 8'(busy), 8'd1);
      idx++;
    end
    valid = 1'b0;
    while (idx < 120) begin
      tick();
      checkOutput($sformatf("bp_txd%0d", idx), 8'(txd), 8'(stream[idx]));
      checkOutput($sformatf("bp_busy%0d", idx), 8'(busy), 8'd1);
      idx++;
    end
    tick();
    checkOutput("bp_busy_end", 8'(busy), 8'd0);
    checkOutput("bp_txd_end", 8'(txd), 8'd1);
    checkOutput("bp_level_end", 8'(level), 8'd0);

    // Queue three codes, then reset at frame cycle 10 (inside the T bit).
    valid = 1'b1;
    {l, t, p} = 3'b101;
    tick();
    {l, t, p} = 3'b011;
    tick();
    {l, t, p} = 3'b110;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checkOutput("mid_busy_c9", 8'(busy), 8'd1);
    checkOutput("mid_txd_c9", 8'(txd), 8'd0);
    checkOutput("mid_level_c9", 8'(level), 8'd2);
    rstN = 1'b0;
    tick();
    checkOutput("mid_rst_txd", 8'(txd), 8'd1);
    checkOutput("mid_rst_busy", 8'(busy), 8'd0);
    checkOutput("mid_rst_level", 8'(level), 8'd0);
    checkOutput("mid_rst_ready", 8'(ready), 8'd0);
    rstN = 1'b1;
    tick();
    checkOutput("mid_rel_ready", 8'(ready), 8'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput($sformatf("mid_quiet_txd%0d", i), 8'(txd), 8'd1);
      checkOutput($sformatf("mid_quiet_busy%0d", i), 8'(busy), 8'd0);
    end
    checkOutput("mid_quiet_level", 8'(level), 8'd0);

    // One-cycle bits: {0,1,1} gives 0,0,1,1,1,1.
    fb = 6'b111100;
    valid1 = 1'b1;
    {l1, t1, p1} = 3'b011;
    tick();
    valid1 = 1'b0;
    {l1, t1, p1} = 3'b100;
    checkOutput("bc1_level", 8'(level1), 8'd1);
    for (int b = 0; b < 6; b++) begin
      tick();
      checkOutput($sformatf("bc1_txd%0d", b), 8'(txd1), 8'(fb[b]));
      checkOutput($sformatf("bc1_busy%0d", b), 8'(busy1), 8'd1);
    end
    tick();
    checkOutput("bc1_busy_end", 8'(busy1), 8'd0);
    checkOutput("bc1_txd_end", 8'(txd1), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
